// File: rtl/ob_bist_if.sv
// ob_bist_if: harness/netlist-facing bus of the BIST controller
interface ob_bist_if;
  logic       start;
  logic [2:0] golden;
  logic [2:0] dut_s;
  logic [3:0] pat;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] sig;
  modport master (output start, golden, dut_s, input pat, busy, done, pass, sig);
  modport slave (input start, golden, dut_s, output pat, busy, done, pass, sig);
endinterface

// File: rtl/ob_bist_ctrl.sv
// ob_bist_ctrl: LFSR pattern BIST with latency-aligned MISR compaction and golden compare
module ob_bist_ctrl #(
  parameter int unsigned NPAT = 16,
  parameter int unsigned LAT = 2,
  parameter logic [3:0] SEED = 4'b1001
) (
  input logic CLK,
  input logic RST,
  ob_bist_if.slave bus
);
  localparam logic [3:0] SEED_E = (SEED == 4'd0) ? 4'b0001 : SEED;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] lfsr_q, lfsr_d, pat_q, pat_d, nxt;
  logic [7:0] cnt_q, cnt_d;
  logic [LAT-1:0] vp_q, vp_d;
  logic [2:0] misr_q, misr_d, s;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, go, last, cmp;
  always_comb begin
    s = bus.dut_s;
    cmp = misr_q == bus.golden;
    go = (state_q == IDLE) && bus.start;
    last = cnt_q == 8'((state_q == RUN) ? NPAT - 1 : LAT - 1);
    nxt = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    state_d = (state_q == IDLE) ? (bus.start ? RUN : IDLE) :
              (state_q == RUN) ? (last ? FLUSH : RUN) :
              (state_q == FLUSH) ? (last ? DONE : FLUSH) : IDLE;
    cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    lfsr_d = go ? SEED_E : (state_q == RUN) ? nxt : lfsr_q;
    pat_d = (state_d == RUN) ? lfsr_d : 4'd0;
    vp_d = (vp_q << 1) | LAT'(state_q == RUN);
    misr_d = go ? 3'd0 :
             vp_q[LAT-1] ? {misr_q[1] ^ misr_q[2] ^ s[2], misr_q[0] ^ s[1], misr_q[2] ^ s[0]} : misr_q;
    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = state_d == DONE;
    pass_d = go ? 1'b0 : done_q ? cmp : pass_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lfsr_q <= SEED_E;
      pat_q <= 4'd0;
      cnt_q <= 8'd0;
      vp_q <= '0;
      misr_q <= 3'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      pat_q <= pat_d;
      cnt_q <= cnt_d;
      vp_q <= vp_d;
      misr_q <= misr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign bus.pat = pat_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sig = misr_q;
  assign bus.pass = done_q ? cmp : pass_q;
endmodule

// File: tb/tb_ob_bist_ctrl.sv
// tb_ob_bist_ctrl: directed checks of ob_bist_ctrl across default, short-run and zero-seed builds
module tb_ob_bist_ctrl;
  logic CLK = 1'b0;
  logic RST;
  logic use_net;
  logic [2:0] r1, r2;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  ob_bist_if i0 ();
  ob_bist_if i1 ();
  ob_bist_if i2 ();
  ob_bist_if i3 ();
  ob_bist_ctrl u0 (.CLK(CLK), .RST(RST), .bus(i0.slave));
  ob_bist_ctrl #(.NPAT(1)) u1 (.CLK(CLK), .RST(RST), .bus(i1.slave));
  ob_bist_ctrl #(.NPAT(2)) u2 (.CLK(CLK), .RST(RST), .bus(i2.slave));
  ob_bist_ctrl #(.SEED(4'b0000)) u3 (.CLK(CLK), .RST(RST), .bus(i3.slave));
  function automatic logic [3:0] lfsr_nx(input logic [3:0] l);
    return {l[2:0], l[3] ^ l[2]};
  endfunction
  function automatic logic [2:0] misr_nx(input logic [2:0] m, input logic [2:0] s);
    return {m[1] ^ m[2] ^ s[2], m[0] ^ s[1], m[2] ^ s[0]};
  endfunction
  function automatic logic [2:0] net_f(input logic [3:0] i);
    return {i[3] ^ i[0], i[2] & i[1], i[1] | i[3]};
  endfunction
  always_ff @(posedge CLK) begin
    r1 <= net_f(i0.pat);
    r2 <= r1;
  end
  assign i0.dut_s = use_net ? r2 : 3'b000;
  assign i1.dut_s = 3'b111;
  assign i2.dut_s = 3'b111;
  assign i3.dut_s = 3'b101;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [3:0] l;
    logic [3:0] first4 [4];
    logic [2:0] m, exp3, expn;
    int b0, b1, b2, d0, d3, dc0, dc1, dc2, dc3, ndone, idle, ok;
    first4 = '{4'b1001, 4'b0011, 4'b0110, 4'b1101};
    m = 3'd0;
    for (int k = 0; k < 16; k++) m = misr_nx(m, 3'b101);
    exp3 = m;
    m = 3'd0;
    l = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      m = misr_nx(m, net_f(l));
      l = lfsr_nx(l);
    end
    expn = m;
    RST = 1'b1;
    use_net = 1'b0;
    i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0; i3.start = 1'b0;
    i0.golden = 3'b000; i1.golden = 3'b111; i2.golden = 3'b100; i3.golden = 3'b000;
    tick;
    tick;
    chk("rst_pat", 8'(i0.pat), 8'd0);
    chk("rst_busy", 8'(i0.busy), 8'd0);
    chk("rst_done", 8'(i0.done), 8'd0);
    chk("rst_pass", 8'(i0.pass), 8'd0);
    chk("rst_sig", 8'(i0.sig), 8'd0);
    RST = 1'b0;
    tick;
    i0.start = 1'b1; i1.start = 1'b1; i2.start = 1'b1; i3.start = 1'b1;
    tick;
    i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0; i3.start = 1'b0;
    b0 = 0; b1 = 0; b2 = 0; d0 = 0; d3 = 0; dc0 = 0; dc1 = 0; dc2 = 0; dc3 = 0;
    l = 4'b1001;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 4) chk("pat_first4", 8'(i0.pat), 8'(first4[c-1]));
      if (c <= 16) begin
        chk("pat_seq", 8'(i0.pat), 8'(l));
        l = lfsr_nx(l);
      end
      if (c == 17) chk("pat_flush_zero", 8'(i0.pat), 8'd0);
      if (c == 1) chk("pat_seed0", 8'(i3.pat), 8'b0001);
      chk("busy_done_excl", 8'(i0.busy & i0.done), 8'd0);
      if (i0.busy) b0++;
      if (i1.busy) b1++;
      if (i2.busy) b2++;
      if (i0.done) begin
        d0++; dc0 = c;
        chk("sig_stub", 8'(i0.sig), 8'd0);
        chk("pass_stub", 8'(i0.pass), 8'd1);
      end
      if (i1.done) begin
        dc1 = c;
        chk("sig_n1", 8'(i1.sig), 8'b111);
        chk("pass_n1", 8'(i1.pass), 8'd1);
      end
      if (i2.done) begin
        dc2 = c;
        chk("sig_n2", 8'(i2.sig), 8'b100);
        chk("pass_n2", 8'(i2.pass), 8'd1);
      end
      if (i3.done) begin
        d3++; dc3 = c;
        chk("sig_seed0", 8'(i3.sig), 8'(exp3));
      end
      if (c == 22) begin
        chk("pass_held", 8'(i1.pass), 8'd1);
        chk("sig_held", 8'(i1.sig), 8'b111);
      end
      i3.start = (c == 5) || (c == 17);
      tick;
    end
    chk("busy_len", 8'(b0), 8'd18);
    chk("done_cyc", 8'(dc0), 8'd19);
    chk("done_cnt", 8'(d0), 8'd1);
    chk("busy_len_n1", 8'(b1), 8'd3);
    chk("done_cyc_n1", 8'(dc1), 8'd4);
    chk("busy_len_n2", 8'(b2), 8'd4);
    chk("done_cyc_n2", 8'(dc2), 8'd5);
    chk("done_cnt_ign", 8'(d3), 8'd1);
    chk("done_cyc_ign", 8'(dc3), 8'd19);
    i1.golden = 3'b110;
    i1.start = 1'b1;
    tick;
    i1.start = 1'b0;
    chk("pass_clr", 8'(i1.pass), 8'd0);
    chk("sig_clr", 8'(i1.sig), 8'd0);
    ok = 0;
    for (int c = 1; c <= 10 && ok == 0; c++) begin
      if (i1.done) begin
        ok = 1;
        chk("sig_n1_b", 8'(i1.sig), 8'b111);
        chk("pass_n1_bad", 8'(i1.pass), 8'd0);
      end else tick;
    end
    chk("done_seen_n1", 8'(ok), 8'd1);
    use_net = 1'b1;
    i0.golden = expn;
    i0.start = 1'b1;
    tick;
    ndone = 0;
    idle = 0;
    for (int c = 1; c <= 60 && ndone < 2; c++) begin
      if (i0.done) begin
        ndone++;
        chk("sig_net", 8'(i0.sig), 8'(expn));
        chk("pass_net", 8'(i0.pass), 8'd1);
      end else if (ndone == 1 && !i0.busy) idle++;
      if (ndone < 2) tick;
    end
    i0.start = 1'b0;
    chk("two_runs", 8'(ndone), 8'd2);
    chk("idle_gap", 8'(idle), 8'd1);
    tick;
    tick;
    i0.start = 1'b1;
    tick;
    i0.start = 1'b0;
    repeat (4) tick;
    chk("pat5", 8'(i0.pat), 8'b1010);
    chk("busy_mid", 8'(i0.busy), 8'd1);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("mrst_pat", 8'(i0.pat), 8'd0);
    chk("mrst_busy", 8'(i0.busy), 8'd0);
    chk("mrst_done", 8'(i0.done), 8'd0);
    chk("mrst_pass", 8'(i0.pass), 8'd0);
    chk("mrst_sig", 8'(i0.sig), 8'd0);
    tick;
    chk("mrst_idle", 8'(i0.busy), 8'd0);
    i0.start = 1'b1;
    tick;
    i0.start = 1'b0;
    chk("restart_pat", 8'(i0.pat), 8'b1001);
    ok = 0;
    b0 = 0;
    for (int c = 1; c <= 30 && ok == 0; c++) begin
      if (i0.busy) b0++;
      if (i0.done) begin
        ok = 1;
        chk("restart_sig", 8'(i0.sig), 8'(expn));
        chk("restart_pass", 8'(i0.pass), 8'd1);
      end else tick;
    end
    chk("restart_done", 8'(ok), 8'd1);
    chk("restart_busy", 8'(b0), 8'd18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ob_bist_ctrl.md
# ob_bist_ctrl

Built-in self-test controller for the two-stage registered 4-input/3-output observability test netlists. It drives the netlist input bus with a 4-bit LFSR pattern sequence and accounts for the netlist's register latency. It compacts the 3-bit netlist output into a MISR signature and reports pass/fail against a supplied golden signature through a start/done handshake. It sits between the test harness and one netlist instance. All sequencing logic is in this block; the netlist is unchanged.

## Interface
- NPAT, 16, number of patterns applied per run; legal range 1..255.
- LAT, 2, cycles from a pattern on `pat` to its response valid on `dut_s`; legal range 1..7.
- SEED, 4'b1001, LFSR start value; a value of 0 is replaced by 4'b0001.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- golden  in  3  expected final signature; sampled in the cycle `done` is high.
- dut_s  in  3  netlist output bus (S).
- pat  out  4  netlist input bus (I[3:0]); registered.
- busy  out  1  high from the first RUN cycle through the last FLUSH cycle.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  (sig == golden) result; held until the next accepted start.
- sig  out  3  MISR signature; live during a run, held afterwards.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE, start=1: go to RUN. Load the LFSR with SEED, clear the MISR, clear the pattern counter and `pass`.
  - RUN: present `pat` = LFSR state and advance the LFSR every cycle. After NPAT patterns, go to FLUSH.
  - FLUSH: lasts exactly LAT cycles, then go to DONE.
  - DONE: lasts one cycle, then go to IDLE.
- `pat` = 0 in every state other than RUN.
- LFSR (x^4+x^3+1, left shift): next = {l[2:0], l[3]^l[2]}. Period is 15. Patterns repeat when NPAT > 15, which is legal.
- Capture valid pipeline: a LAT-deep shift register. A 1 enters in each RUN cycle and a 0 in all other cycles.
  - When its output is 1, the MISR updates from `dut_s` that cycle.
  - Exactly NPAT updates occur per run.
- MISR update:
  - m0' = m2 ^ s0
  - m1' = m0 ^ s1
  - m2' = m1 ^ m2 ^ s2
- `sig` = MISR state.
- DONE: `done`=1 and `pass` is registered as (sig == golden). The MISR is frozen.
- `start` is ignored outside IDLE. `start` held high continuously in IDLE launches back-to-back runs, with one IDLE cycle between runs.
- RST at any time, including mid-run, gives: state IDLE, `pat`=0, `busy`=0, `done`=0, `pass`=0, `sig`=0, LFSR=SEED, valid pipe cleared.

## Timing
- Edge e0 samples start=1 in IDLE. RUN covers the NPAT cycles after e0, and `pat` holds the k-th pattern in the k-th of those cycles.
- `busy` is high for exactly NPAT+LAT consecutive cycles.
- `done` and `pass` become valid in the cycle after the last FLUSH cycle. That is cycle NPAT+LAT+1 counted from e0.
- The response to the pattern in cycle t is captured at the edge ending cycle t+LAT. The last capture therefore lands in the final FLUSH cycle.
- `sig` is final in the DONE cycle and is held until the next accepted start.
- `done` is never high together with `busy`.

## Test plan
- Defaults, netlist stubbed with `dut_s` = 0:
  - `pat` sequence starts 1001, 0011, 0110, 1101.
  - `busy` high for 18 cycles, then `done` pulses.
  - sig=000; with golden=000, pass=1.
- NPAT=1, `dut_s` tied to 3'b111:
  - sig=111, busy for 3 cycles.
  - golden=111 gives pass=1; golden=110 gives pass=0.
- NPAT=2, `dut_s` tied to 3'b111: sig=100 at done.
- Real netlist attached, defaults, run twice back-to-back:
  - identical `sig` both runs, matching the reference-model signature.
  - exactly one IDLE cycle between the runs.
- RST asserted in the 5th RUN cycle:
  - next cycle all outputs are 0 and the FSM is in IDLE.
  - a new start gives a correct full run from pattern 1001.
- `start` pulsed during RUN and during FLUSH: ignored, with no extra `done` and an unchanged signature. Repeat with SEED=0: the first pattern is 0001.
